// File: rtl/hwpe_stream_package.sv
// Shared types and defaults for the TCDM store FIFO.
// The store FIFO optionally merges same-address writes when HWPE_STREAM_STORE_FIFO_MERGE_EN is defined.
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_STORE_FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned HWPE_STREAM_STORE_ADDR_WIDTH_DEFAULT = 32;
  localparam int unsigned HWPE_STREAM_STORE_DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned HWPE_STREAM_STORE_BE_WIDTH_DEFAULT   = HWPE_STREAM_STORE_DATA_WIDTH_DEFAULT / 8;

  // One buffered write at the default TCDM widths.
  typedef struct packed {
    logic [HWPE_STREAM_STORE_ADDR_WIDTH_DEFAULT-1:0] add;
    logic [HWPE_STREAM_STORE_BE_WIDTH_DEFAULT-1:0]   be;
    logic [HWPE_STREAM_STORE_DATA_WIDTH_DEFAULT-1:0] data;
  } hwpe_stream_store_entry_t;

endpackage

// File: rtl/hwpe_stream_fifo_ptr_ctrl.sv
// Read/write pointers, occupancy and full/empty flags for a power-of-2 FIFO.
// Pointers wrap naturally; the count register disambiguates full from empty.
module hwpe_stream_fifo_ptr_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_d, rd_ptr_d;
  logic [CW-1:0] count_d;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointer/count; clear wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    count_d  = count;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count + CW'(1);
        2'b01:   count_d = count - CW'(1);
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      count  <= count_d;
      full   <= (count_d == CW'(DEPTH));
      empty  <= (count_d == CW'(0));
    end
  end

endmodule

// File: rtl/hwpe_stream_tcdm_store_fifo.sv
// Write-side decoupling FIFO between a TCDM store stage and the interconnect.
// Define HWPE_STREAM_STORE_FIFO_MERGE_EN to merge a write into the tail entry on address match.
module hwpe_stream_tcdm_store_fifo
  import hwpe_stream_package::*;
#(
  parameter int unsigned FIFO_DEPTH = HWPE_STREAM_STORE_FIFO_DEPTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH = HWPE_STREAM_STORE_ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = HWPE_STREAM_STORE_DATA_WIDTH_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         tcdm_slave_req_i,
  output logic                         tcdm_slave_gnt_o,
  input  logic [ADDR_WIDTH-1:0]        tcdm_slave_add_i,
  input  logic                         tcdm_slave_wen_i,
  input  logic [DATA_WIDTH/8-1:0]      tcdm_slave_be_i,
  input  logic [DATA_WIDTH-1:0]        tcdm_slave_data_i,
  output logic                         tcdm_slave_r_valid_o,
  output logic                         tcdm_master_req_o,
  input  logic                         tcdm_master_gnt_i,
  output logic [ADDR_WIDTH-1:0]        tcdm_master_add_o,
  output logic                         tcdm_master_wen_o,
  output logic [DATA_WIDTH/8-1:0]      tcdm_master_be_o,
  output logic [DATA_WIDTH-1:0]        tcdm_master_data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(FIFO_DEPTH):0]  count_o,
  output logic                         rd_err_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        wr_entry;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, gnt;

  assign wr_entry = {tcdm_slave_add_i, tcdm_slave_be_i, tcdm_slave_data_i};
  assign pop      = ~empty & tcdm_master_gnt_i;

`ifdef HWPE_STREAM_STORE_FIFO_MERGE_EN
  logic [PW-1:0] tail_ptr;
  logic          tail_pop, merge_ok, merge;
  entry_t        merged;

  assign tail_ptr = wr_ptr - PW'(1);
  // The tail is also the head only when a single entry is buffered.
  assign tail_pop = pop & (count == CW'(1));
  assign merge_ok = ~empty & ~tcdm_slave_wen_i & ~tail_pop &
                    (tcdm_slave_add_i == mem_q[tail_ptr].add);
  assign gnt      = ~full | merge_ok;
  assign merge    = tcdm_slave_req_i & merge_ok;
  assign push     = tcdm_slave_req_i & gnt & ~tcdm_slave_wen_i & ~merge_ok;

  always_comb begin
    merged    = mem_q[tail_ptr];
    merged.be = mem_q[tail_ptr].be | tcdm_slave_be_i;
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      if (tcdm_slave_be_i[b]) merged.data[8*b +: 8] = tcdm_slave_data_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      if (push)       mem_q[wr_ptr]   <= wr_entry;
      else if (merge) mem_q[tail_ptr] <= merged;
    end
  end
`else
  assign gnt  = ~full;
  assign push = tcdm_slave_req_i & gnt & ~tcdm_slave_wen_i;

  always_ff @(posedge clk_i) begin
    if (!clear_i && push) mem_q[wr_ptr] <= wr_entry;
  end
`endif

  hwpe_stream_fifo_ptr_ctrl #(
    .DEPTH (FIFO_DEPTH)
  ) i_ptr_ctrl (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (clear_i),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Reads are not supported: grant them, drop them, and flag it until reset/clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_err_o <= 1'b0;
    end else if (clear_i) begin
      rd_err_o <= 1'b0;
    end else if (tcdm_slave_req_i & gnt & tcdm_slave_wen_i) begin
      rd_err_o <= 1'b1;
    end
  end

  assign tcdm_slave_gnt_o     = gnt;
  assign tcdm_slave_r_valid_o = 1'b0;
  assign tcdm_master_req_o    = ~empty;
  assign tcdm_master_wen_o    = 1'b0;
  assign tcdm_master_add_o    = mem_q[rd_ptr].add;
  assign tcdm_master_be_o     = mem_q[rd_ptr].be;
  assign tcdm_master_data_o   = mem_q[rd_ptr].data;
  assign empty_o              = empty;
  assign full_o               = full;
  assign count_o              = count;

endmodule
